// File: rtl/xosera_pkg.sv
// Shared Xosera bus constants and the bus-master state type.
package xv;

  localparam logic cs_ENABLED  = 1'b0;
  localparam logic cs_DISABLED = 1'b1;
  localparam logic RnW_READ    = 1'b1;
  localparam logic RnW_WRITE   = 1'b0;

  typedef enum logic [1:0] {BM_IDLE, BM_SETUP, BM_STROBE, BM_HOLD} bm_state_t;

endpackage

// File: rtl/xosera_bus_master.sv
// Host-side initiator: splits 16-bit register requests into even/odd byte
// strobe cycles on the Xosera 8-bit bus with programmable setup/strobe/hold.
module xosera_bus_master
  import xv::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic        req_word_i,
  input  logic        req_bytesel_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_rdata_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  localparam int MAX_ST  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_ST > HOLD_CYCLES) ? MAX_ST : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("xosera_bus_master: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
  end

  bm_state_t       r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_second, w_second_nxt;
  logic            r_word, w_word_nxt;
  logic [7:0]      r_wdata_lo, w_wdata_lo_nxt;
  logic [15:0]     r_rdbuf, w_rdbuf_nxt;
  logic            r_cs_n, w_cs_n_nxt;
  logic            r_rd_nwr, w_rd_nwr_nxt;
  logic [3:0]      r_reg_num, w_reg_num_nxt;
  logic            r_bytesel, w_bytesel_nxt;
  logic [7:0]      r_data, w_data_nxt;
  logic            r_oe, w_oe_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0]     r_rsp_rdata, w_rsp_rdata_nxt;

  logic w_cnt_last;
  logic w_is_read;
  logic w_even_word;

  assign w_cnt_last  = (r_cnt == CW'(1));
  assign w_is_read   = (r_rd_nwr == RnW_READ);
  assign w_even_word = r_word && !r_second;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_second_nxt    = r_second;
    w_word_nxt      = r_word;
    w_wdata_lo_nxt  = r_wdata_lo;
    w_rdbuf_nxt     = r_rdbuf;
    w_cs_n_nxt      = r_cs_n;
    w_rd_nwr_nxt    = r_rd_nwr;
    w_reg_num_nxt   = r_reg_num;
    w_bytesel_nxt   = r_bytesel;
    w_data_nxt      = r_data;
    w_oe_nxt        = r_oe;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;

    case (r_state)
      BM_IDLE: begin
        if (req_valid_i) begin
          w_state_nxt    = BM_SETUP;
          w_cnt_nxt      = C_SETUP;
          w_second_nxt   = 1'b0;
          w_word_nxt     = req_word_i;
          w_wdata_lo_nxt = req_wdata_i[7:0];
          w_rdbuf_nxt    = 16'h0000;
          w_cs_n_nxt     = cs_DISABLED;
          w_rd_nwr_nxt   = req_rd_nwr_i;
          w_reg_num_nxt  = req_reg_num_i;
          w_bytesel_nxt  = req_word_i ? 1'b0 : req_bytesel_i;
          w_oe_nxt       = (req_rd_nwr_i == RnW_WRITE);
          if (req_rd_nwr_i == RnW_WRITE)
            w_data_nxt = req_word_i ? req_wdata_i[15:8] : req_wdata_i[7:0];
          else
            w_data_nxt = 8'h00;
        end
      end
      BM_SETUP: begin
        if (w_cnt_last) begin
          w_state_nxt = BM_STROBE;
          w_cnt_nxt   = C_STROBE;
          w_cs_n_nxt  = cs_ENABLED;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      BM_STROBE: begin
        if (w_cnt_last) begin
          w_state_nxt = BM_HOLD;
          w_cnt_nxt   = C_HOLD;
          w_cs_n_nxt  = cs_DISABLED;
          // Even byte of a word lands in [15:8]; everything else in [7:0].
          if (w_is_read)
            w_rdbuf_nxt = w_even_word ? {bus_data_i, r_rdbuf[7:0]} : {r_rdbuf[15:8], bus_data_i};
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      BM_HOLD: begin
        if (w_cnt_last) begin
          if (w_even_word) begin
            w_state_nxt   = BM_SETUP;
            w_cnt_nxt     = C_SETUP;
            w_second_nxt  = 1'b1;
            w_bytesel_nxt = 1'b1;
            if (!w_is_read)
              w_data_nxt = r_wdata_lo;
          end else begin
            w_state_nxt     = BM_IDLE;
            w_oe_nxt        = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = r_rdbuf;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = BM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state     <= BM_IDLE;
      r_cnt       <= '0;
      r_second    <= 1'b0;
      r_word      <= 1'b0;
      r_wdata_lo  <= 8'h00;
      r_rdbuf     <= 16'h0000;
      r_cs_n      <= cs_DISABLED;
      r_rd_nwr    <= RnW_READ;
      r_reg_num   <= 4'h0;
      r_bytesel   <= 1'b0;
      r_data      <= 8'h00;
      r_oe        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_second    <= w_second_nxt;
      r_word      <= w_word_nxt;
      r_wdata_lo  <= w_wdata_lo_nxt;
      r_rdbuf     <= w_rdbuf_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_rd_nwr    <= w_rd_nwr_nxt;
      r_reg_num   <= w_reg_num_nxt;
      r_bytesel   <= w_bytesel_nxt;
      r_data      <= w_data_nxt;
      r_oe        <= w_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign req_ready_o   = (r_state == BM_IDLE);
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign bus_cs_n_o    = r_cs_n;
  assign bus_rd_nwr_o  = r_rd_nwr;
  assign bus_reg_num_o = r_reg_num;
  assign bus_bytesel_o = r_bytesel;
  assign bus_data_o    = r_data;
  assign bus_data_oe_o = r_oe;

endmodule

// File: tb/tb_xosera_bus_master.sv
// Randomized bench for xosera_bus_master: a cycle-indexed timeline model of the
// bus, checked every cycle, plus literal checks for the directed scenarios.
module tb_xosera_bus_master;

  localparam int S = 1, T = 2, H = 1;
  localparam int P = S + T + H;
  localparam int MAXC = 8192;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_rd_nwr_i = 1'b0;
  logic [3:0]  req_reg_num_i = 4'h0;
  logic        req_word_i = 1'b0;
  logic        req_bytesel_i = 1'b0;
  logic [15:0] req_wdata_i = 16'h0;
  logic        rsp_valid_o;
  logic [15:0] rsp_rdata_o;
  logic        bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i = 8'h00;

  logic        valid_2 = 1'b0;
  logic        ready_2, rsp_valid_2, cs_n_2, rd_nwr_2, bytesel_2, oe_2;
  logic [15:0] rdata_2;
  logic [3:0]  reg_num_2;
  logic [7:0]  data_2;
  logic [7:0]  din_2 = 8'h00;

  xosera_bus_master #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) u_dut (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_nwr_i(req_rd_nwr_i), .req_reg_num_i(req_reg_num_i),
    .req_word_i(req_word_i), .req_bytesel_i(req_bytesel_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o), .bus_reg_num_o(bus_reg_num_o),
    .bus_bytesel_o(bus_bytesel_o), .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i(bus_data_i)
  );

  xosera_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut_2 (
    .clk(clk), .reset_i(reset_i),
    .req_valid_i(valid_2), .req_ready_o(ready_2),
    .req_rd_nwr_i(1'b0), .req_reg_num_i(4'h6),
    .req_word_i(1'b1), .req_bytesel_i(1'b0), .req_wdata_i(16'h3C96),
    .rsp_valid_o(rsp_valid_2), .rsp_rdata_o(rdata_2),
    .bus_cs_n_o(cs_n_2), .bus_rd_nwr_o(rd_nwr_2), .bus_reg_num_o(reg_num_2),
    .bus_bytesel_o(bytesel_2), .bus_data_o(data_2), .bus_data_oe_o(oe_2),
    .bus_data_i(din_2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    end
  endtask

  // Timeline model: expected bus state for every cycle index.
  logic        e_cs  [MAXC];
  logic        e_oe  [MAXC];
  logic        e_rsp [MAXC];
  logic [1:0]  e_mode[MAXC];   // 0 don't-care fields, 1 active request, 2 reset values
  logic [3:0]  e_reg [MAXC];
  logic        e_rnw [MAXC];
  logic        e_bs  [MAXC];
  logic [7:0]  e_data[MAXC];
  logic [15:0] e_rval[MAXC];
  logic [7:0]  din   [MAXC];

  logic        l_cs [MAXC], l_oe [MAXC], l_rsp[MAXC], l_bs[MAXC], l_rdy[MAXC];
  logic [7:0]  l_data[MAXC];
  logic [15:0] l_rdata[MAXC];
  logic        l2_cs[MAXC], l2_rsp[MAXC], l2_oe[MAXC], l2_rdy[MAXC];

  logic [7:0]  dev_rb0 = 8'h00, dev_rb1 = 8'h00;
  int          acc_count = 0;
  int          acc_cyc = 0;

  initial begin : compare
    int free_at;
    logic [15:0] exp_rdata;
    free_at = 0;
    exp_rdata = 16'h0;
    for (int i = 0; i < MAXC; i++) begin
      e_cs[i] = 1'b1; e_oe[i] = 1'b0; e_rsp[i] = 1'b0; e_mode[i] = 2'd0;
      e_reg[i] = 4'h0; e_rnw[i] = 1'b1; e_bs[i] = 1'b0; e_data[i] = 8'h0;
      e_rval[i] = 16'h0; din[i] = 8'($urandom);
    end
    forever begin
      @(negedge clk);
      if (cyc >= 1 && cyc < MAXC) begin
        int c;
        c = cyc;
        if (e_rsp[c]) exp_rdata = e_rval[c];
        chk("cs_n", c, bus_cs_n_o, e_cs[c]);
        chk("data_oe", c, bus_data_oe_o, e_oe[c]);
        chk("rsp_valid", c, rsp_valid_o, e_rsp[c]);
        chk("req_ready", c, req_ready_o, (c >= free_at));
        chk("rsp_rdata", c, rsp_rdata_o, exp_rdata);
        if (e_mode[c] == 2'd1) begin
          chk("reg_num", c, bus_reg_num_o, e_reg[c]);
          chk("rd_nwr", c, bus_rd_nwr_o, e_rnw[c]);
          chk("bytesel", c, bus_bytesel_o, e_bs[c]);
          if (e_oe[c]) chk("wdata", c, bus_data_o, e_data[c]);
        end else if (e_mode[c] == 2'd2) begin
          chk("rst_reg_num", c, bus_reg_num_o, 4'h0);
          chk("rst_rd_nwr", c, bus_rd_nwr_o, 1'b1);
          chk("rst_bytesel", c, bus_bytesel_o, 1'b0);
          chk("rst_data", c, bus_data_o, 8'h00);
        end
        l_cs[c] = bus_cs_n_o; l_oe[c] = bus_data_oe_o; l_rsp[c] = rsp_valid_o;
        l_bs[c] = bus_bytesel_o; l_rdy[c] = req_ready_o; l_data[c] = bus_data_o;
        l_rdata[c] = rsp_rdata_o;
        l2_cs[c] = cs_n_2; l2_rsp[c] = rsp_valid_2; l2_oe[c] = oe_2; l2_rdy[c] = ready_2;

        if (reset_i) begin
          for (int k = c + 1; k < MAXC; k++) begin
            e_cs[k] = 1'b1; e_oe[k] = 1'b0; e_rsp[k] = 1'b0; e_mode[k] = 2'd2;
          end
          free_at = c + 1;
          exp_rdata = 16'h0;
        end else if (req_valid_i && c >= free_at) begin
          int nb, n;
          logic rd;
          nb = req_word_i ? 2 : 1;
          n  = nb * P;
          rd = req_rd_nwr_i;
          for (int b = 0; b < nb; b++) begin
            for (int k = 1; k <= P; k++) begin
              int x;
              x = c + b * P + k;
              if (x < MAXC) begin
                e_mode[x] = 2'd1;
                e_cs[x]   = (k > S && k <= S + T) ? 1'b0 : 1'b1;
                e_oe[x]   = !rd;
                e_rnw[x]  = rd;
                e_reg[x]  = req_reg_num_i;
                e_bs[x]   = req_word_i ? (b == 1) : req_bytesel_i;
                e_data[x] = (req_word_i && b == 0) ? req_wdata_i[15:8] : req_wdata_i[7:0];
                e_rsp[x]  = 1'b0;
              end
            end
            if (c + b * P + S + T < MAXC)
              din[c + b * P + S + T] = (b == 0) ? dev_rb0 : dev_rb1;
          end
          for (int k = c + n + 1; k < MAXC; k++) e_mode[k] = 2'd0;
          if (c + n + 1 < MAXC) begin
            e_rsp[c + n + 1]  = 1'b1;
            e_rval[c + n + 1] = !rd ? 16'h0 : (req_word_i ? {dev_rb0, dev_rb1} : {8'h00, dev_rb0});
          end
          free_at = c + n + 1;
          acc_cyc = c;
          acc_count++;
        end
      end
    end
  end

  // Device read-data drive: returns the scheduled byte on the last strobe
  // cycle and random junk on every other cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if (cyc < MAXC) bus_data_i = din[cyc];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic rd, input logic [3:0] rg, input logic wd, input logic bs,
                      input logic [15:0] w, input logic [7:0] rb0, input logic [7:0] rb1,
                      output int acc);
    int start;
    bit got;
    req_rd_nwr_i = rd; req_reg_num_i = rg; req_word_i = wd; req_bytesel_i = bs;
    req_wdata_i = w; dev_rb0 = rb0; dev_rb1 = rb1;
    req_valid_i = 1'b1;
    start = acc_count;
    got = 1'b0;
    acc = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      step();
      if (acc_count != start) begin
        got = 1'b1;
        acc = acc_cyc;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL accept_timeout cycle %0d: got no accept expected accept within 64 cycles", cyc);
    end
  endtask

  initial begin : main
    int a, b, lows;
    logic any;
    repeat (3) step();
    reset_i = 1'b0;
    idle(2);

    // Word write, reg 3, 16'hA55A
    send(1'b0, 4'h3, 1'b1, 1'b0, 16'hA55A, 8'h00, 8'h00, a);
    idle(12);
    chk("ww_cs1", a + 1, l_cs[a + 1], 1'b1);
    chk("ww_cs2", a + 2, l_cs[a + 2], 1'b0);
    chk("ww_cs3", a + 3, l_cs[a + 3], 1'b0);
    chk("ww_cs4", a + 4, l_cs[a + 4], 1'b1);
    chk("ww_cs5", a + 5, l_cs[a + 5], 1'b1);
    chk("ww_cs6", a + 6, l_cs[a + 6], 1'b0);
    chk("ww_cs7", a + 7, l_cs[a + 7], 1'b0);
    chk("ww_cs8", a + 8, l_cs[a + 8], 1'b1);
    chk("ww_bs_even", a + 2, l_bs[a + 2], 1'b0);
    chk("ww_data_even", a + 2, l_data[a + 2], 8'hA5);
    chk("ww_bs_odd", a + 6, l_bs[a + 6], 1'b1);
    chk("ww_data_odd", a + 6, l_data[a + 6], 8'h5A);
    for (int k = 1; k <= 8; k++) chk("ww_oe", a + k, l_oe[a + k], 1'b1);
    chk("ww_oe_end", a + 9, l_oe[a + 9], 1'b0);
    chk("ww_rsp8", a + 8, l_rsp[a + 8], 1'b0);
    chk("ww_rsp9", a + 9, l_rsp[a + 9], 1'b1);
    chk("ww_rdy8", a + 8, l_rdy[a + 8], 1'b0);
    chk("ww_rdy9", a + 9, l_rdy[a + 9], 1'b1);

    // Word read, reg 5, device returns 12 then 34
    send(1'b1, 4'h5, 1'b1, 1'b0, 16'hFFFF, 8'h12, 8'h34, a);
    idle(12);
    chk("wr_rsp9", a + 9, l_rsp[a + 9], 1'b1);
    chk("wr_rdata9", a + 9, l_rdata[a + 9], 16'h1234);
    any = 1'b0;
    for (int k = 1; k <= 9; k++) any = any | l_oe[a + k];
    chk("wr_oe_never", a, any, 1'b0);

    // Byte read, bytesel 1, device returns C3
    send(1'b1, 4'h7, 1'b0, 1'b1, 16'hFFFF, 8'hC3, 8'h00, a);
    idle(8);
    chk("br_rsp5", a + 5, l_rsp[a + 5], 1'b1);
    chk("br_rdata5", a + 5, l_rdata[a + 5], 16'h00C3);
    chk("br_bs", a + 2, l_bs[a + 2], 1'b1);
    lows = 0;
    for (int k = 1; k <= 5; k++) if (!l_cs[a + k]) lows++;
    chk("br_cs_low_count", a, lows, 2);

    // Two queued word writes with valid held
    send(1'b0, 4'h1, 1'b1, 1'b0, 16'h1111, 8'h00, 8'h00, a);
    send(1'b0, 4'h2, 1'b1, 1'b0, 16'h2222, 8'h00, 8'h00, b);
    idle(14);
    chk("q_accept2", b, b, a + 9);
    chk("q_cs10", a + 10, l_cs[a + 10], 1'b1);
    chk("q_cs11", a + 11, l_cs[a + 11], 1'b0);
    chk("q_cs12", a + 12, l_cs[a + 12], 1'b0);
    chk("q_data11", a + 11, l_data[a + 11], 8'h22);
    chk("q_oe10", a + 10, l_oe[a + 10], 1'b1);

    // Reset during the first strobe cycle
    send(1'b0, 4'h4, 1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h00, a);
    req_valid_i = 1'b0;
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    idle(12);
    chk("rst_cs_live", a + 2, l_cs[a + 2], 1'b0);
    chk("rst_cs3", a + 3, l_cs[a + 3], 1'b1);
    chk("rst_oe3", a + 3, l_oe[a + 3], 1'b0);
    chk("rst_rdy3", a + 3, l_rdy[a + 3], 1'b1);
    chk("rst_bs3", a + 3, l_bs[a + 3], 1'b0);
    chk("rst_data3", a + 3, l_data[a + 3], 8'h00);
    any = 1'b0;
    for (int k = 3; k <= 12; k++) any = any | l_rsp[a + k] | ~l_cs[a + k];
    chk("rst_no_rsp_no_cs", a, any, 1'b0);

    // S=2, T=3, H=2 instance
    a = cyc;
    valid_2 = 1'b1;
    step();
    valid_2 = 1'b0;
    repeat (18) step();
    chk("p_rdy0", a, l2_rdy[a], 1'b1);
    chk("p_oe1", a + 1, l2_oe[a + 1], 1'b1);
    chk("p_cs2", a + 2, l2_cs[a + 2], 1'b1);
    for (int k = 3; k <= 5; k++) chk("p_cs_lo1", a + k, l2_cs[a + k], 1'b0);
    chk("p_cs6", a + 6, l2_cs[a + 6], 1'b1);
    chk("p_cs9", a + 9, l2_cs[a + 9], 1'b1);
    for (int k = 10; k <= 12; k++) chk("p_cs_lo2", a + k, l2_cs[a + k], 1'b0);
    chk("p_cs13", a + 13, l2_cs[a + 13], 1'b1);
    chk("p_rsp14", a + 14, l2_rsp[a + 14], 1'b0);
    chk("p_rsp15", a + 15, l2_rsp[a + 15], 1'b1);
    chk("p_rdy15", a + 15, l2_rdy[a + 15], 1'b1);

    // Randomized traffic with back-to-back, gaps and occasional resets
    for (int i = 0; i < 150; i++) begin
      send(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
           8'($urandom), 8'($urandom), a);
      if ($urandom_range(0, 24) == 0) begin
        idle($urandom_range(0, 8));
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
      end else if ($urandom_range(0, 2) != 0) begin
        idle($urandom_range(0, 12));
      end
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog cycle %0d: got no finish expected finish before time limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
